// File: rtl/seq_rotate_right.sv
// rtl/seq_rotate_right.sv - iterative one-bit-per-clock right rotator; SEQ_ROTATE_RIGHT_LOGICAL_EN adds a logical-shift mode
module seq_rotate_right #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
`ifdef SEQ_ROTATE_RIGHT_LOGICAL_EN
    input  logic             in_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] data;
    logic [AMT_W-1:0] count;
    logic             accept;
    logic             fill;

`ifdef SEQ_ROTATE_RIGHT_LOGICAL_EN
    logic             mode;
`endif

    // A job is taken only from IDLE; in_ready is decoded from state so this never sees DONE.
    assign accept = in_valid && (state == IDLE);

    // The result lives in the working register; it is left untouched after handoff until the next accept.
    assign out_data = data;

    // Bit shifted in at the top: wrap-around for rotate, zero for logical shift.
`ifdef SEQ_ROTATE_RIGHT_LOGICAL_EN
    always_comb begin
        fill = data[0];
        if (mode) begin
            fill = 1'b0;
        end
    end
`else
    always_comb begin
        fill = data[0];
    end
`endif

    // State register; reset abandons any in-flight job.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs, all decoded from state only.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_amt == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (count == AMT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Working register and step counter: load on accept, one bit position per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data  <= '0;
            count <= '0;
        end else if (accept) begin
            data  <= in_data;
            count <= in_amt;
        end else if (state == SHIFT) begin
            data  <= {fill, data[WIDTH-1:1]};
            count <= count - AMT_W'(1);
        end
    end

`ifdef SEQ_ROTATE_RIGHT_LOGICAL_EN
    // Mode is sampled with the job so mid-job changes on in_mode have no effect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode <= 1'b0;
        end else if (accept) begin
            mode <= in_mode;
        end
    end
`endif

endmodule

// File: tb/tb_seq_rotate_right.sv
// tb/tb_seq_rotate_right.sv - self-checking bench for seq_rotate_right
module tb_seq_rotate_right;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [7:0] in_data   = 8'h00;
    logic [2:0] in_amt    = 3'd0;
    logic       in_mode   = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       busy;

    int errors = 0;
    int checks = 0;

    seq_rotate_right #(.WIDTH(8), .AMT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
`ifdef SEQ_ROTATE_RIGHT_LOGICAL_EN
        .in_mode   (in_mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] d, input int amt, input logic m);
        logic [15:0] w;
        if (m) begin
            return d >> amt;
        end
        w = {d, d} >> amt;
        return w[7:0];
    endfunction

    task automatic run_job(input logic [7:0] d, input int amt, input logic m,
                           input int stall, input logic [7:0] exp);
        int edges;
        @(negedge clk);
        check("ready_before_accept", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = amt[2:0];
        in_mode   = m;
        out_ready = 1'b0;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_amt   = 3'($urandom);
        in_mode  = 1'($urandom);
        while (!out_valid && edges < 40) begin
            check("ready_low_in_shift", in_ready, 0);
            check("busy_in_shift", busy, 1);
            in_valid = 1'($urandom);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("latency", edges, (amt == 0) ? 1 : amt + 1);
        check("result", out_data, exp);
        check("busy_done", busy, 1);
        check("ready_done", in_ready, 0);
        repeat (stall) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, exp);
            check("stall_ready", in_ready, 0);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("handoff_valid", out_valid, 0);
        check("handoff_ready", in_ready, 1);
        check("handoff_busy", busy, 0);
        check("persist_data", out_data, exp);
    endtask

    initial begin
        int seen;
        logic [7:0] d;
        int a;
        logic m;
        int st;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_ready", in_ready, 1);
        rst_n = 1'b1;

        run_job(8'h26, 3, 1'b0, 0, 8'hC4);
        run_job(8'hC4, 0, 1'b0, 0, 8'hC4);
        run_job(8'h01, 7, 1'b0, 0, 8'h02);
        run_job(8'h80, 1, 1'b0, 0, 8'h40);
        run_job(8'h5A, 5, 1'b0, 5, model(8'h5A, 5, 1'b0));

        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_amt   = 3'd6;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_busy", busy, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_ready", in_ready, 1);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_partial_result", seen, 0);

        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        in_amt   = 3'd0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("done_before_rst", out_valid, 1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("donerst_valid", out_valid, 0);
        check("donerst_data", out_data, 8'h00);
        check("donerst_ready", in_ready, 1);
        rst_n = 1'b1;

`ifdef SEQ_ROTATE_RIGHT_LOGICAL_EN
        run_job(8'hC4, 3, 1'b1, 0, 8'h18);
        run_job(8'hC4, 3, 1'b0, 2, 8'h98);
`else
        run_job(8'hC4, 3, 1'b0, 2, 8'h98);
`endif

        for (int i = 0; i < 24; i++) begin
            d  = 8'($urandom);
            a  = $urandom_range(0, 7);
`ifdef SEQ_ROTATE_RIGHT_LOGICAL_EN
            m  = 1'($urandom);
`else
            m  = 1'b0;
`endif
            st = $urandom_range(0, 3);
            run_job(d, a, m, st, model(d, a, m));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
